// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and constants for the div_sched divider slice.
//   state_e   : scheduler FSM states (IDLE, DIV, DONE)
//   DEF_WIDTH : default operand width
//   DEF_NREQ  : default number of requesters
//   DBZ_Q()   : quotient returned on divide by zero (all ones, widths up to 63)
package div_sched_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [63:0] DBZ_Q(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/div_sched_if.sv
// div_sched_if: request/response bundle between arithmetic clients and div_sched.
//   req_valid/req_ready : per-requester request handshake (NREQ bits each)
//   req_a/req_b         : packed dividends/divisors, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_q/rsp_r/rsp_dbz : owner id, quotient, remainder, divide-by-zero flag
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A valid holder keeps its payload stable until that edge; ready may
// depend combinationally on valid, valid never depends on ready.
// Modports: master = clients/consumer side, slave = divider side.
interface div_sched_if
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_q;
    logic [WIDTH-1:0]      rsp_r;
    logic                  rsp_dbz;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz
    );

endinterface

// File: rtl/div_sched_step.sv
// div_step: one combinational restoring-division step.
//   rem_i     : partial remainder (always < b_i)
//   quo_msb_i : next dividend bit shifted into the remainder
//   b_i       : divisor
//   rem_o     : next partial remainder
//   q_bit_o   : quotient bit produced by this step
module div_step
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             quo_msb_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] diff;

    assign t       = {rem_i, quo_msb_i};
    assign q_bit_o = (t >= {1'b0, b_i});
    // When subtracting, t-b < b fits in WIDTH bits, so modulo-2^WIDTH arithmetic is exact.
    assign diff    = t[WIDTH-1:0] - b_i;
    assign rem_o   = q_bit_o ? diff : t[WIDTH-1:0];

endmodule

// File: rtl/div_sched.sv
// div_sched: shared iterative restoring divider with round-robin scheduling.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   bus         : div_sched_if.slave (request and response handshakes)
//   dbg_state_o : current FSM state
// Optional feature macro DIV_SCHED_UNIT_SHORTCUT_EN: when defined, a divisor of 1
// completes directly (q=a, r=0) one cycle after accept instead of iterating.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic         clk,
    input  logic         rst,
    div_sched_if.slave   bus,
    output state_e       dbg_state_o
);
    localparam int IDW   = $clog2(NREQ);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] Q_ONES = WIDTH'(DBZ_Q(WIDTH));

    state_e           state_q;
    logic [IDW-1:0]   rr_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] rem_q, quo_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_valid_q, rsp_dbz_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_q_q, rsp_r_q;

    logic             found;
    logic [IDW-1:0]   grant;
    logic [NREQ-1:0]  ready;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;

    // Round-robin search: first valid requester at or above rr_q, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == IDLE && found && !rst) ready[grant] = 1'b1;
    end

    assign a_sel = bus.req_a[grant*WIDTH +: WIDTH];
    assign b_sel = bus.req_b[grant*WIDTH +: WIDTH];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i    (rem_q),
        .quo_msb_i(quo_q[WIDTH-1]),
        .b_i      (b_q),
        .rem_o    (rem_nx),
        .q_bit_o  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dbz_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        b_q  <= b_sel;
                        id_q <= grant;
                        rr_q <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        if (b_sel == '0) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_q_q     <= Q_ONES;
                            rsp_r_q     <= a_sel;
                            rsp_dbz_q   <= 1'b1;
                            rsp_id_q    <= grant;
`ifdef DIV_SCHED_UNIT_SHORTCUT_EN
                        end else if (b_sel == WIDTH'(1)) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_q_q     <= a_sel;
                            rsp_r_q     <= '0;
                            rsp_dbz_q   <= 1'b0;
                            rsp_id_q    <= grant;
`endif
                        end else begin
                            state_q <= DIV;
                            rem_q   <= '0;
                            quo_q   <= a_sel;
                            cnt_q   <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    if (cnt_q == '0) begin
                        // Last step: publish the final quotient/remainder directly.
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_q_q     <= {quo_q[WIDTH-2:0], q_bit};
                        rsp_r_q     <= rem_nx;
                        rsp_dbz_q   <= 1'b0;
                        rsp_id_q    <= id_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_q     = rsp_q_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_dbz   = rsp_dbz_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed bench for div_sched (WIDTH=4, NREQ=2).
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;
    localparam int RW    = IDW + 1 + 2 * WIDTH;
`ifdef DIV_SCHED_UNIT_SHORTCUT_EN
    localparam int UNIT_LAT = 1;
`else
    localparam int UNIT_LAT = 5;
`endif

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    div_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errs   = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] pack_rsp(input logic [IDW-1:0] id, input logic dbz,
                                               input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
        return {id, dbz, q, r};
    endfunction

    function automatic logic [RW-1:0] obs_rsp();
        return {bus.rsp_id, bus.rsp_dbz, bus.rsp_q, bus.rsp_r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents a request and returns a_cyc = accept cycle; returns at the negedge of cycle A+1.
    task automatic send(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit hold, output int a_cyc);
        bus.req_valid[id] = 1'b1;
        bus.req_a[id*WIDTH +: WIDTH] = a;
        bus.req_b[id*WIDTH +: WIDTH] = b;
        a_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.req_ready[id]) begin
                a_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (a_cyc < 0) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (!hold) bus.req_valid[id] = 1'b0;
    endtask

    // Waits for rsp_valid, checks latency (when exp_lat > 0) and payload against exp_q.
    task automatic wait_rsp(input string tag, input int a_cyc, input int exp_lat);
        int lat;
        logic [RW-1:0] e;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid) begin
                lat = cyc - a_cyc;
                break;
            end
            @(negedge clk);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (lat < 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_rsp"}, obs_rsp(), e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a_cyc;
        int last_cyc;
        int hits;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst           = 1'b1;

        // Reset state, with requests already pending.
        bus.req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp", obs_rsp(), 0);
        check("rst_state", dbg_state, IDLE);
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request 13/3.
        bus.rsp_ready = 1'b1;
        exp_q.push_back(pack_rsp(0, 0, 4, 1));
        send(0, 4'd13, 4'd3, 1'b0, a_cyc);
        wait_rsp("single", a_cyc, 5);
        @(negedge clk);
        check("single_drop", bus.rsp_valid, 0);
        check("single_hold", obs_rsp(), pack_rsp(0, 0, 4, 1));

        // Fairness: both requesters held valid after reset, grants alternate 0,1,0,1.
        do_reset();
        bus.req_a = {4'd15, 4'd9};
        bus.req_b = {4'd4, 4'd2};
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++)
            exp_q.push_back((i % 2 == 0) ? pack_rsp(0, 0, 4, 1) : pack_rsp(1, 0, 3, 3));
        last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_rsp("rr", 0, 0);
            if (i > 0) check("rr_gap", cyc - last_cyc, 6);
            last_cyc = cyc;
            @(negedge clk);
        end
        bus.req_valid = '0;
        @(negedge clk);

        // Divide by zero from requester 1.
        exp_q.push_back(pack_rsp(1, 1, 15, 7));
        send(1, 4'd7, 4'd0, 1'b0, a_cyc);
        wait_rsp("dbz", a_cyc, 1);
        @(negedge clk);

        // Backpressure: response held 6 cycles, req0 stays valid.
        bus.rsp_ready = 1'b0;
        exp_q.push_back(pack_rsp(0, 0, 0, 5));
        send(0, 4'd5, 4'd7, 1'b1, a_cyc);
        wait_rsp("bp", a_cyc, 5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold", {bus.rsp_valid, obs_rsp()}, {1'b1, pack_rsp(0, 0, 0, 5)});
            check("bp_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_drop", bus.rsp_valid, 0);
        check("bp_next_ready", bus.req_ready, 2'b01);
        bus.req_valid = '0;
        @(negedge clk);

        // Reset in the middle of a division.
        send(0, 4'd14, 4'd3, 1'b0, a_cyc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", bus.rsp_valid, 0);
        check("mid_rst_rsp", obs_rsp(), 0);
        check("mid_rst_state", dbg_state, IDLE);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) hits++;
        end
        check("mid_rst_no_rsp", hits, 0);
        exp_q.push_back(pack_rsp(0, 0, 4, 2));
        send(0, 4'd14, 4'd3, 1'b0, a_cyc);
        wait_rsp("after_rst", a_cyc, 5);
        @(negedge clk);

        // Divisor of one.
        exp_q.push_back(pack_rsp(0, 0, 15, 0));
        send(0, 4'd15, 4'd1, 1'b0, a_cyc);
        wait_rsp("unit", a_cyc, UNIT_LAT);
        @(negedge clk);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
